// File: rtl/food_spawner.sv
// Picks a free playfield cell for the snake food: LFSR draw, margin reject, body-occupancy query.
// Accepted cell reported as pixel coordinates with a valid pulse, or a fail pulse after MAX_TRIES draws.
module food_spawner #(
  parameter int          GRID_COLS = 64,
  parameter int          GRID_ROWS = 48,
  parameter int          CELL_PX   = 10,
  parameter int          MARGIN    = 2,
  parameter int          X_W       = 10,
  parameter int          Y_W       = 9,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 15
) (
  input  logic           VGA_clk,
  input  logic           reset,
  input  logic           req,
  output logic           busy,
  output logic           valid,
  output logic           fail,
  output logic [X_W-1:0] rand_X,
  output logic [Y_W-1:0] rand_Y,
  output logic           chk_valid,
  output logic [X_W-1:0] chk_X,
  output logic [Y_W-1:0] chk_Y,
  input  logic           chk_hit
);

  localparam int CW = $clog2(GRID_COLS);
  localparam int RW = $clog2(GRID_ROWS);
  localparam int TW = $clog2(MAX_TRIES + 1);

  localparam logic [15:0]    SEED_EFF = (SEED == 16'd0) ? 16'd1 : SEED;
  localparam logic [15:0]    TAPS     = 16'hB400;
  localparam logic [CW-1:0]  COL_MIN  = CW'(MARGIN);
  localparam logic [CW-1:0]  COL_MAX  = CW'(GRID_COLS - 1 - MARGIN);
  localparam logic [RW-1:0]  ROW_MIN  = RW'(MARGIN);
  localparam logic [RW-1:0]  ROW_MAX  = RW'(GRID_ROWS - 1 - MARGIN);
  localparam logic [X_W-1:0] PX_X     = X_W'(CELL_PX);
  localparam logic [Y_W-1:0] PX_Y     = Y_W'(CELL_PX);
  localparam logic [X_W-1:0] RST_X    = X_W'(MARGIN * CELL_PX);
  localparam logic [Y_W-1:0] RST_Y    = Y_W'(MARGIN * CELL_PX);
  localparam logic [TW-1:0]  MAX_T    = TW'(MAX_TRIES);

  typedef enum logic [1:0] {IDLE, DRAW, CHECK, WAIT} state_t;

  state_t         state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [TW-1:0]  tries_q, tries_d;
  logic [X_W-1:0] chk_x_q, chk_x_d, rand_x_q, rand_x_d;
  logic [Y_W-1:0] chk_y_q, chk_y_d, rand_y_q, rand_y_d;
  logic           valid_q, valid_d, fail_q, fail_d;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           in_range;

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      tries_q  <= '0;
      chk_x_q  <= '0;
      chk_y_q  <= '0;
      rand_x_q <= RST_X;
      rand_y_q <= RST_Y;
      valid_q  <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      tries_q  <= tries_d;
      chk_x_q  <= chk_x_d;
      chk_y_q  <= chk_y_d;
      rand_x_q <= rand_x_d;
      rand_y_q <= rand_y_d;
      valid_q  <= valid_d;
      fail_q   <= fail_d;
    end
  end

  // Free-running Galois LFSR and the candidate cell it currently encodes.
  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    col      = lfsr_q[CW-1:0];
    row      = lfsr_q[8 +: RW];
    cand_x   = X_W'(col) * PX_X;
    cand_y   = Y_W'(row) * PX_Y;
    in_range = (col >= COL_MIN) && (col <= COL_MAX) && (row >= ROW_MIN) && (row <= ROW_MAX);
  end

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    chk_x_d  = chk_x_q;
    chk_y_d  = chk_y_q;
    rand_x_d = rand_x_q;
    rand_y_d = rand_y_q;
    valid_d  = 1'b0;
    fail_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // The result-pulse cycle does not accept a new request.
        if (req && !valid_q && !fail_q) begin
          tries_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        tries_d = tries_q + TW'(1);
        if (in_range) begin
          chk_x_d = cand_x;
          chk_y_d = cand_y;
          state_d = CHECK;
        end else if ((tries_q + TW'(1)) == MAX_T) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end
      end
      CHECK: state_d = WAIT;
      WAIT: begin
        if (!chk_hit) begin
          rand_x_d = chk_x_q;
          rand_y_d = chk_y_q;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end else if (tries_q == MAX_T) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    chk_valid = (state_q == CHECK);
    valid     = valid_q;
    fail      = fail_q;
    rand_X    = rand_x_q;
    rand_Y    = rand_y_q;
    chk_X     = chk_x_q;
    chk_Y     = chk_y_q;
  end

endmodule

// File: tb/tb_food_spawner.sv
// Bench for food_spawner: transaction-level schedule model checked every cycle, plus literal pins.
module tb_food_spawner;

  localparam int          N        = 2048;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int          SPAN     = 64;
  localparam int          LO       = 2;
  localparam int          COL_HI   = 61;
  localparam int          ROW_HI   = 45;
  localparam int          PX       = 10;
  localparam int          TRIES    = 15;
  localparam int          RST_PIX  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       busy, valid, fail, chk_valid, chk_hit;
  logic [9:0] rand_X, chk_X;
  logic [8:0] rand_Y, chk_Y;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int q_cnt    = 0;
  int q_base   = 0;
  int n_hits   = 0;
  int n_chk    = 0;
  int n_val    = 0;
  int n_fl     = 0;
  int cq_x[$];
  int cq_y[$];

  logic [15:0] lf     [N];
  bit          e_busy [N];
  bit          e_chk  [N];
  bit          e_val  [N];
  bit          e_fail [N];
  bit          e_hold [N];
  int          e_cx   [N];
  int          e_cy   [N];
  int          e_rx   [N];
  int          e_ry   [N];

  assign chk_hit = ((q_cnt - q_base) <= n_hits);

  food_spawner dut (
    .VGA_clk  (clk),
    .reset    (reset),
    .req      (req),
    .busy     (busy),
    .valid    (valid),
    .fail     (fail),
    .rand_X   (rand_X),
    .rand_Y   (rand_Y),
    .chk_valid(chk_valid),
    .chk_X    (chk_X),
    .chk_Y    (chk_Y),
    .chk_hit  (chk_hit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Idle expectations from cycle 0 after a reset; LFSR value known for every cycle.
  task automatic init_model();
    lf[0] = SEED;
    for (int i = 0; i < N; i++) begin
      if (i > 0) lf[i] = lstep(lf[i-1]);
      e_busy[i] = 0; e_chk[i] = 0; e_val[i] = 0; e_fail[i] = 0; e_hold[i] = 0;
      e_cx[i] = 0; e_cy[i] = 0; e_rx[i] = RST_PIX; e_ry[i] = RST_PIX;
    end
  endtask

  // Request accepted at the end of cycle k: lay out draws, queries and the result pulse.
  task automatic plan(input int k, output int e, output int first_chk);
    int t, tries, q, col, row;
    bit done;
    t = k + 1; tries = 0; q = 0; done = 0; e = -1; first_chk = -1;
    while (!done && (t + 3 < N)) begin
      tries++;
      col = int'(lf[t]) % SPAN;
      row = (int'(lf[t]) >> 8) % SPAN;
      e_busy[t] = 1;
      if (col >= LO && col <= COL_HI && row >= LO && row <= ROW_HI) begin
        q++;
        if (first_chk < 0) first_chk = t + 1;
        e_chk[t+1] = 1;
        for (int j = t + 1; j <= t + 2; j++) begin
          e_busy[j] = 1; e_hold[j] = 1; e_cx[j] = col * PX; e_cy[j] = row * PX;
        end
        if (q > n_hits) begin
          e_val[t+3] = 1;
          for (int j = t + 3; j < N; j++) begin
            e_rx[j] = col * PX; e_ry[j] = row * PX;
          end
          e = t + 3; done = 1;
        end else if (tries == TRIES) begin
          e_fail[t+3] = 1; e = t + 3; done = 1;
        end else begin
          t = t + 3;
        end
      end else if (tries == TRIES) begin
        e_fail[t+1] = 1; e = t + 1; done = 1;
      end else begin
        t = t + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (valid || fail) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) chk("pulse_timeout", 0, 1);
  endtask

  initial begin
    fork
      begin : compare
        forever begin
          @(negedge clk);
          if (!reset) begin
            if (chk_valid) begin
              q_cnt++; n_chk++;
              cq_x.push_back(int'(chk_X)); cq_y.push_back(int'(chk_Y));
            end
            if (valid) n_val++;
            if (fail) n_fl++;
            chk("valid_and_fail", int'(valid && fail), 0);
            if (cyc < N) begin
              chk("busy", busy, e_busy[cyc]);
              chk("chk_valid", chk_valid, e_chk[cyc]);
              chk("valid", valid, e_val[cyc]);
              chk("fail", fail, e_fail[cyc]);
              chk("rand_X", rand_X, e_rx[cyc]);
              chk("rand_Y", rand_Y, e_ry[cyc]);
              if (e_hold[cyc]) begin
                chk("chk_X", chk_X, e_cx[cyc]);
                chk("chk_Y", chk_Y, e_cy[cyc]);
              end
            end
          end
        end
      end
      begin : stimulus
        int k, e, fc, e2, fc2, at, c0, v0, f0, zero_seen, early;
        init_model();
        tick(); tick();
        reset = 1'b0;

        // Idle after reset.
        repeat (10) tick();
        chk("idle_rand_X", rand_X, 20);
        chk("idle_rand_Y", rand_Y, 20);
        chk("idle_chk_X", chk_X, 0);
        chk("idle_busy", busy, 0);
        chk("idle_no_query", n_chk, 0);
        chk("model_lfsr1", lf[1], 16'hE270);
        chk("model_lfsr11", lf[11], 16'hAC58);

        // Single spawn, no body hit.
        n_hits = 0; q_base = q_cnt; cq_x.delete(); cq_y.delete();
        c0 = n_chk; v0 = n_val;
        k = cyc; req = 1'b1; plan(k, e, fc);
        tick(); req = 1'b0;
        wait_pulse(at);
        chk("t2_latency", at - k, 4);
        chk("t2_rand_X", rand_X, 240);
        chk("t2_rand_Y", rand_Y, 440);
        tick();
        chk("t2_one_query", n_chk - c0, 1);
        chk("t2_one_valid", n_val - v0, 1);
        tick();

        // Body everywhere: exhaust the draw budget.
        n_hits = 1000; q_base = q_cnt;
        c0 = n_chk; v0 = n_val; f0 = n_fl;
        k = cyc; req = 1'b1; plan(k, e, fc);
        tick(); req = 1'b0;
        wait_pulse(at);
        chk("t3_fail_time", at, e);
        tick();
        chk("t3_fail_once", n_fl - f0, 1);
        chk("t3_no_valid", n_val - v0, 0);
        chk("t3_query_le_max", int'((n_chk - c0) <= TRIES), 1);
        chk("t3_rand_held", rand_X, 240);
        chk("t3_busy_dropped", busy, 0);
        tick();

        // Two hits then free.
        n_hits = 2; q_base = q_cnt; cq_x.delete(); cq_y.delete();
        c0 = n_chk; v0 = n_val;
        k = cyc; req = 1'b1; plan(k, e, fc);
        tick(); req = 1'b0;
        wait_pulse(at);
        tick();
        chk("t4_three_queries", n_chk - c0, 3);
        chk("t4_one_valid", n_val - v0, 1);
        if (cq_x.size() == 3) begin
          chk("t4_distinct", int'((cq_x[0] != cq_x[1] || cq_y[0] != cq_y[1]) &&
                                  (cq_x[1] != cq_x[2] || cq_y[1] != cq_y[2]) &&
                                  (cq_x[0] != cq_x[2] || cq_y[0] != cq_y[2])), 1);
          chk("t4_rand_is_third", rand_X, cq_x[2]);
        end
        tick();

        // req held through the valid cycle: next spawn starts one cycle later.
        n_hits = 0; q_base = q_cnt; v0 = n_val;
        k = cyc; req = 1'b1; plan(k, e, fc);
        if (e < 0) e = cyc;
        while (cyc < e + 1) tick();
        plan(e + 1, e2, fc2);
        if (e2 < 0) e2 = cyc;
        q_base = q_base + 1;
        tick(); req = 1'b0;
        while (cyc < e2 + 1) tick();
        chk("t4b_two_valids", n_val - v0, 2);
        tick();

        // req held, reset asserted in WAIT: request aborted, nothing queued.
        n_hits = 0; q_base = q_cnt;
        k = cyc; req = 1'b1; plan(k, e, fc);
        if (fc < 0) fc = cyc;
        while (cyc < fc + 1) tick();
        reset = 1'b1;
        init_model();
        v0 = n_val; f0 = n_fl;
        tick();
        reset = 1'b0; req = 1'b0;
        repeat (10) tick();
        chk("t5_no_valid", n_val - v0, 0);
        chk("t5_no_fail", n_fl - f0, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rand_X", rand_X, 20);
        chk("t5_rand_Y", rand_Y, 20);
        chk("t5_chk_X", chk_X, 0);

        // LFSR period.
        reset = 1'b1; init_model();
        tick();
        reset = 1'b0;
        chk("lfsr_reset", dut.lfsr_q, SEED);
        zero_seen = 0; early = 0;
        for (int n = 1; n <= 65535; n++) begin
          tick();
          if (dut.lfsr_q == 16'h0000) zero_seen++;
          if (n < 65535 && dut.lfsr_q == SEED) early++;
        end
        chk("lfsr_period", dut.lfsr_q, SEED);
        chk("lfsr_never_zero", zero_seen, 0);
        chk("lfsr_no_early_repeat", early, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
      end
    join_any
  end

endmodule
